// File: rtl/autoencoder_pkg.sv
// Shared autoencoder definitions: instruction memory geometry and loader state encoding,
// used by the instruction memory, the PC counter and the instruction loader.
package autoencoder_pkg;

   localparam int IMEM_DEPTH  = 32;
   localparam int IMEM_ADDR_W = 5;
   localparam int INSTR_W     = 16;
   localparam int BYTE_W      = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_HI    = 3'd2,
      ST_LO    = 3'd3,
      ST_WRITE = 3'd4,
      ST_CSUM  = 3'd5,
      ST_DONE  = 3'd6,
      ST_ERR   = 3'd7
   } loader_state_e;

endpackage

// File: rtl/loader_csum.sv
// Running XOR accumulator over the loader byte stream; clear wins over enable.
// Instantiated by instr_mem_loader only when INSTR_LOADER_CHECKSUM_EN is defined.
module loader_csum
   import autoencoder_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              enable,
   input  logic [BYTE_W-1:0] data_in,
   output logic [BYTE_W-1:0] acc
);

   logic [BYTE_W-1:0] acc_q;
   logic [BYTE_W-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (enable) begin
         acc_d = acc_q ^ data_in;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Host-side byte-stream writer for the instruction memory; holds the core until the program is loaded.
// Optional trailing XOR checksum is enabled by defining INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader
   import autoencoder_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load_start,
   input  logic [BYTE_W-1:0]  rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               core_run,
   output logic               load_err
);

   localparam logic [BYTE_W:0] DEPTH_LIMIT = (BYTE_W+1)'(DEPTH);

   loader_state_e      state_q, state_d;
   logic [BYTE_W-1:0]  n_q, n_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [BYTE_W-1:0]  hi_q, hi_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  waddr_q, waddr_d;
   logic [INSTR_W-1:0] wdata_q, wdata_d;
   logic               run_q, run_d;
   logic               err_q, err_d;

   logic               xfer;
   logic               len_bad;
   logic               last_word;

   // A pending load_start blocks the byte so it cannot be consumed by the aborted load.
   assign rx_ready = !load_start &&
                     ((state_q == ST_LEN) || (state_q == ST_HI) ||
                      (state_q == ST_LO)  || (state_q == ST_CSUM));
   assign xfer      = rx_valid && rx_ready;
   assign len_bad   = (rx_data == '0) || ({1'b0, rx_data} > DEPTH_LIMIT);
   assign last_word = (BYTE_W'(addr_q) == (n_q - BYTE_W'(1)));

`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] csum_acc;
   logic              csum_en;

   assign csum_en = xfer && ((state_q == ST_LEN) || (state_q == ST_HI) || (state_q == ST_LO));

   loader_csum u_csum (
      .clock   (clock),
      .reset   (reset),
      .clear   (load_start),
      .enable  (csum_en),
      .data_in (rx_data),
      .acc     (csum_acc)
   );
`endif

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      addr_d  = addr_q;
      hi_d    = hi_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;

      if (load_start) begin
         state_d = ST_LEN;
         addr_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_LEN: begin
               if (xfer) begin
                  n_d = rx_data;
                  if (len_bad) begin
                     state_d = ST_ERR;
                  end else begin
                     addr_d  = '0;
                     state_d = ST_HI;
                  end
               end
            end
            ST_HI: begin
               if (xfer) begin
                  hi_d    = rx_data;
                  state_d = ST_LO;
               end
            end
            ST_LO: begin
               // Output address/data change only here so they stay stable outside WRITE.
               if (xfer) begin
                  wdata_d = {hi_q, rx_data};
                  waddr_d = addr_q;
                  state_d = ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (last_word) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = ST_HI;
               end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (xfer) begin
                  state_d = (rx_data == csum_acc) ? ST_DONE : ST_ERR;
               end
            end
`endif
            ST_DONE: begin
               state_d = ST_DONE;
            end
            ST_ERR: begin
               state_d = ST_ERR;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      we_d  = (state_d == ST_WRITE);
      run_d = (state_d == ST_DONE);
      err_d = (state_d == ST_ERR);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         n_q     <= '0;
         addr_q  <= '0;
         hi_q    <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         run_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         addr_q  <= addr_d;
         hi_q    <= hi_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         run_q   <= run_d;
         err_q   <= err_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = waddr_q;
   assign imem_wdata = wdata_q;
   assign core_run   = run_q;
   assign load_err   = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized and directed bench for instr_mem_loader; expected results come from a
// stream-level model of what a load should write and whether it should succeed.
module tb_instr_mem_loader;

`ifdef INSTR_LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        load_start = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        imem_we;
   logic [4:0]  imem_addr;
   logic [15:0] imem_wdata;
   logic        core_run;
   logic        load_err;

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;

   int          wr_total = 0;
   logic [4:0]  log_addr [4096];
   logic [15:0] log_data [4096];
   int          log_time [4096];

   instr_mem_loader dut (
      .clock      (clock),
      .reset      (reset),
      .load_start (load_start),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_run   (core_run),
      .load_err   (load_err)
   );

   // Free-running clock and cycle counter used to time write strobes
   always #5 clock = ~clock;

   always @(posedge clock) cycle++;

   // Every write strobe is logged mid-cycle so loads can be checked against the model afterwards
   always @(negedge clock) begin
      if (imem_we === 1'b1) begin
         if (wr_total < 4096) begin
            log_addr[wr_total] = imem_addr;
            log_data[wr_total] = imem_wdata;
            log_time[wr_total] = cycle;
         end
         wr_total++;
      end
   end

   // Single comparison point: counts every vector and reports any miscompare
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Pulses load_start with a competing byte offered; that byte must never be accepted
   task automatic startLoad();
      @(negedge clock);
      load_start = 1'b1;
      rx_valid   = 1'($urandom_range(1));
      rx_data    = 8'hFF;
      #1;
      checkOutput("start_blocks_ready", {31'd0, rx_ready}, 32'd0);
      @(posedge clock);
      #1;
      load_start = 1'b0;
      rx_valid   = 1'b0;
      checkOutput("start_drops_run", {31'd0, core_run}, 32'd0);
      checkOutput("start_drops_err", {31'd0, load_err}, 32'd0);
   endtask

   // Streams bytes; mode 0 holds rx_valid high, 1 toggles it, 2 randomizes it
   task automatic applyStimulus(input logic [7:0] stream[$], input int mode);
      int  idx = 0;
      int  budget = 0;
      bit  accepted;
      while (idx < stream.size() && budget < 2000) begin
         @(negedge clock);
         rx_data = stream[idx];
         case (mode)
            0:       rx_valid = 1'b1;
            1:       rx_valid = (budget % 2 == 0);
            default: rx_valid = ($urandom_range(99) < 55);
         endcase
         #1;
         accepted = rx_valid && rx_ready;
         @(posedge clock);
         if (accepted) idx++;
         budget++;
      end
      @(negedge clock);
      rx_valid = 1'b0;
      checkOutput("stream_consumed", idx, stream.size());
   endtask

   // One complete load: build the stream, send it, then compare the write log and status
   task automatic runLoad(input string tag, input int n, input logic [15:0] words[$],
                          input int mode, input bit bad_csum);
      logic [7:0] stream[$];
      logic [7:0] csum;
      int         base;
      int         exp_writes;
      int         got_writes;
      bit         len_ok;
      bit         exp_ok;

      len_ok     = (n >= 1) && (n <= 32);
      exp_ok     = len_ok && !(CSUM_EN && bad_csum);
      exp_writes = len_ok ? n : 0;

      stream.push_back(8'(n));
      csum = 8'(n);
      if (len_ok) begin
         for (int i = 0; i < n; i++) begin
            stream.push_back(words[i][15:8]);
            stream.push_back(words[i][7:0]);
            csum = csum ^ words[i][15:8] ^ words[i][7:0];
         end
         if (CSUM_EN) stream.push_back(bad_csum ? (csum ^ 8'h01) : csum);
      end

      base = wr_total;
      startLoad();
      applyStimulus(stream, mode);
      repeat (3) @(negedge clock);

      got_writes = wr_total - base;
      checkOutput({tag, "_core_run"}, {31'd0, core_run}, {31'd0, exp_ok});
      checkOutput({tag, "_load_err"}, {31'd0, load_err}, {31'd0, !exp_ok});
      checkOutput({tag, "_writes"}, got_writes, exp_writes);
      for (int i = 0; i < exp_writes && i < got_writes; i++) begin
         checkOutput($sformatf("%s_addr%0d", tag, i), {27'd0, log_addr[base+i]}, i);
         checkOutput($sformatf("%s_data%0d", tag, i), {16'd0, log_data[base+i]}, {16'd0, words[i]});
      end
      if (mode == 0 && exp_writes > 1 && got_writes > 1) begin
         checkOutput({tag, "_spacing"}, log_time[base+1] - log_time[base], 3);
      end
   endtask

   // Directed test-plan scenarios followed by randomized loads
   initial begin
      logic [15:0] words[$];
      logic [7:0]  part[$];
      int          n;

      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      checkOutput("rst_imem_we", {31'd0, imem_we}, 32'd0);
      checkOutput("rst_imem_addr", {27'd0, imem_addr}, 32'd0);
      checkOutput("rst_imem_wdata", {16'd0, imem_wdata}, 32'd0);
      checkOutput("rst_core_run", {31'd0, core_run}, 32'd0);
      checkOutput("rst_load_err", {31'd0, load_err}, 32'd0);

      words = '{16'h1234, 16'hABCD};
      runLoad("two_words", 2, words, 0, 1'b0);

      words = '{};
      runLoad("len_zero", 0, words, 0, 1'b0);
      runLoad("len_33", 33, words, 0, 1'b0);

      words = '{};
      for (int i = 0; i < 32; i++) words.push_back(16'(i * 16'h0101));
      runLoad("full32", 32, words, 0, 1'b0);

      words = '{16'h0F1E, 16'h2D3C, 16'h4B5A};
      runLoad("toggle_valid", 3, words, 1, 1'b0);

      // Abort after one of three words, then a fresh single-word load
      part = '{8'h03, 8'h11, 8'h22};
      startLoad();
      applyStimulus(part, 0);
      repeat (2) @(negedge clock);
      checkOutput("abort_mid_run", {31'd0, core_run}, 32'd0);
      words = '{16'hAA55};
      runLoad("after_abort", 1, words, 0, 1'b0);

      if (CSUM_EN) begin
         words = '{16'h1234};
         runLoad("csum_good", 1, words, 0, 1'b0);
         runLoad("csum_bad", 1, words, 0, 1'b1);
      end

      // Synchronous reset out of DONE clears status and output registers
      words = '{16'h0102, 16'h0304};
      runLoad("pre_reset", 2, words, 0, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("midrst_core_run", {31'd0, core_run}, 32'd0);
      checkOutput("midrst_imem_addr", {27'd0, imem_addr}, 32'd0);
      checkOutput("midrst_imem_wdata", {16'd0, imem_wdata}, 32'd0);
      checkOutput("midrst_rx_ready", {31'd0, rx_ready}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      for (int t = 0; t < 10; t++) begin
         n = ($urandom_range(99) < 15) ? (($urandom_range(1) == 0) ? 0 : $urandom_range(33, 60))
                                       : $urandom_range(1, 32);
         words = '{};
         for (int i = 0; i < 32; i++) words.push_back(16'($urandom));
         runLoad($sformatf("rand%0d", t), n, words, $urandom_range(2),
                 ($urandom_range(99) < 20));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
